// File: rtl/boxcar_decimator_pkg.sv
// -----------------------------------------------------------------------------
// boxcar_decimator_pkg
//   Shared definitions for the boxcar decimator processing chain:
//     - default sample width and accumulator guard width
//     - signed saturation bounds for an arbitrary output width
//     - FIFO occupancy width helper
//     - classification of a stage-2 result against the saturation bounds
// -----------------------------------------------------------------------------
package boxcar_decimator_pkg;

    localparam int DATA_W_DEF  = 64;
    localparam int GUARD_W_DEF = 16;

    // Wide signed type used only to evaluate saturation bounds and compare
    // shifted sums against them. It must be at least DATA_W + GUARD_W bits.
    localparam int SAT_CALC_W = 128;
    typedef logic signed [SAT_CALC_W-1:0] sat_calc_t;

    // Outcome of range-checking a shifted sum against the output width.
    typedef enum logic [1:0] {
        SAT_NONE = 2'd0,
        SAT_HIGH = 2'd1,
        SAT_LOW  = 2'd2
    } sat_kind_t;

    // Largest value representable in a signed data_w-bit word.
    function automatic sat_calc_t sat_max(input int data_w);
        sat_calc_t one;
        one = sat_calc_t'(1);
        return (one <<< (data_w - 1)) - one;
    endfunction

    // Smallest value representable in a signed data_w-bit word.
    function automatic sat_calc_t sat_min(input int data_w);
        sat_calc_t one;
        one = sat_calc_t'(1);
        return -(one <<< (data_w - 1));
    endfunction

    // Occupancy counter width: must represent 0..depth inclusive.
    function automatic int fifo_level_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/boxcar_decimator_fifo.sv
// -----------------------------------------------------------------------------
// sync_fifo_fwft
//   Single-clock show-ahead (first-word-fall-through) FIFO.
//
//   Ports
//     clk        : clock
//     reset_n    : synchronous active-low reset (clears pointers)
//     push       : write request; accepted when not full, or when full and
//                  a pop happens on the same edge
//     push_data  : data written on an accepted push
//     pop        : read request; ignored while empty
//     head_data  : current head entry, forced to zero while empty
//     empty      : no entries stored
//     full       : DEPTH entries stored
//     level      : occupancy, write count minus read count
//
//   DEPTH must be a power of two and at least 2. Pointers carry one extra
//   bit so that full and empty are distinguishable and the difference of
//   the two pointers is the occupancy directly.
// -----------------------------------------------------------------------------
module sync_fifo_fwft
    import boxcar_decimator_pkg::*;
#(
    parameter int WIDTH = DATA_W_DEF,
    parameter int DEPTH = 8
) (
    input  logic                            clk,
    input  logic                            reset_n,
    input  logic                            push,
    input  logic [WIDTH-1:0]                push_data,
    input  logic                            pop,
    output logic [WIDTH-1:0]                head_data,
    output logic                            empty,
    output logic                            full,
    output logic [fifo_level_w(DEPTH)-1:0]  level
);

    localparam int AW    = $clog2(DEPTH);
    localparam int LVL_W = fifo_level_w(DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

    logic [WIDTH-1:0] mem [DEPTH];

    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    logic        push_ok;
    logic        pop_ok;

    assign level = wr_ptr_q - rd_ptr_q;
    assign empty = (level == '0);
    assign full  = (level == LVL_W'(DEPTH));

    // When full, the slot being written is the slot being read, so a push
    // is only safe if the head leaves on the same edge.
    assign push_ok = push && (!full || pop);
    assign pop_ok  = pop && !empty;

    assign head_data = empty ? '0 : mem[rd_ptr_q[AW-1:0]];

    always_comb begin
        // NOTE: every output of a combinational block gets a default first,
        // otherwise any path that skips an assignment infers a latch.
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // NOTE: the storage array is deliberately not reset; pointer reset makes
    // its contents unreachable, and head_data is masked while empty.
    always_ff @(posedge clk) begin
        if (reset_n && push_ok) begin
            mem[wr_ptr_q[AW-1:0]] <= push_data;
        end
    end

endmodule

// File: rtl/boxcar_decimator.sv
// -----------------------------------------------------------------------------
// boxcar_decimator
//   Sums blocks of N consecutive accepted samples, scales each sum by an
//   arithmetic right shift, saturates it to DATA_W bits and queues the result
//   in an output FIFO.
//
//   Ports
//     clk            : clock
//     reset_n        : synchronous active-low reset; while low, decim_factor
//                      and out_shift are latched and all state is cleared
//     enable         : sample acceptance enable
//     data_in        : signed input sample
//     data_in_valid  : data_in qualifier (no upstream backpressure)
//     decim_factor   : block length N (0 means 1), latched during reset
//     out_shift      : right shift applied to each sum, latched during reset
//     data_out       : signed result at the FIFO head (zero when empty)
//     data_out_valid : FIFO not empty
//     data_out_ready : consumer takes data_out on this edge
//     overflow       : sticky; a result saturated or was dropped
//     fifo_level     : FIFO occupancy
//
//   Pipeline, counted from edge E that accepts the last sample of a block:
//     E   : final sum registered in stage 1, accumulator/count cleared
//     E+1 : shifted and saturated result registered in stage 2
//     E+2 : result written into the FIFO, visible on data_out
// -----------------------------------------------------------------------------
module boxcar_decimator
    import boxcar_decimator_pkg::*;
#(
    parameter int DATA_W     = DATA_W_DEF,
    parameter int GUARD_W    = GUARD_W_DEF,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                                clk,
    input  logic                                reset_n,
    input  logic                                enable,
    input  logic signed [DATA_W-1:0]            data_in,
    input  logic                                data_in_valid,
    input  logic [15:0]                         decim_factor,
    input  logic [5:0]                          out_shift,
    output logic signed [DATA_W-1:0]            data_out,
    output logic                                data_out_valid,
    input  logic                                data_out_ready,
    output logic                                overflow,
    output logic [fifo_level_w(FIFO_DEPTH)-1:0] fifo_level
);

    localparam int        ACC_W  = DATA_W + GUARD_W;
    localparam int        LVL_W  = fifo_level_w(FIFO_DEPTH);
    localparam sat_calc_t SAT_HI = sat_max(DATA_W);
    localparam sat_calc_t SAT_LO = sat_min(DATA_W);

    // ---------------------------------------------------------------- config
    logic [15:0] n_q, n_d;
    logic [5:0]  shift_q, shift_d;

    // Configuration tracks the inputs only while reset is held.
    always_comb begin
        n_d     = n_q;
        shift_d = shift_q;
        if (!reset_n) begin
            n_d     = (decim_factor == 16'd0) ? 16'd1 : decim_factor;
            shift_d = out_shift;
        end
    end

    // ----------------------------------------------------------- accumulator
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic [15:0]             cnt_q, cnt_d;
    logic signed [ACC_W-1:0] sample_ext;
    logic signed [ACC_W-1:0] block_sum;
    logic                    accept;
    logic                    last_sample;

    logic                    s1_valid_q, s1_valid_d;
    logic signed [ACC_W-1:0] s1_sum_q, s1_sum_d;

    assign accept      = enable && data_in_valid;
    assign sample_ext  = {{GUARD_W{data_in[DATA_W-1]}}, data_in};
    assign block_sum   = acc_q + sample_ext;
    assign last_sample = (cnt_q == n_q - 16'd1);

    // The closing sample goes straight into stage 1 together with the
    // accumulator, which restarts at zero so the next block has no gap.
    always_comb begin
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        s1_valid_d = 1'b0;
        s1_sum_d   = s1_sum_q;
        if (accept) begin
            if (last_sample) begin
                acc_d      = '0;
                cnt_d      = '0;
                s1_valid_d = 1'b1;
                s1_sum_d   = block_sum;
            end else begin
                acc_d = block_sum;
                cnt_d = cnt_q + 16'd1;
            end
        end
    end

    // ------------------------------------------------- stage 2: scale + clip
    logic signed [ACC_W-1:0] shifted;
    sat_calc_t               shifted_wide;
    sat_kind_t               sat_kind;

    logic                    s2_valid_q, s2_valid_d;
    logic [DATA_W-1:0]       s2_data_q, s2_data_d;
    logic                    s2_sat_q, s2_sat_d;

    assign shifted      = s1_sum_q >>> shift_q;
    assign shifted_wide = sat_calc_t'(shifted);

    always_comb begin
        sat_kind = SAT_NONE;
        if (shifted_wide > SAT_HI) begin
            sat_kind = SAT_HIGH;
        end else if (shifted_wide < SAT_LO) begin
            sat_kind = SAT_LOW;
        end
    end

    always_comb begin
        s2_valid_d = s1_valid_q;
        s2_data_d  = s2_data_q;
        s2_sat_d   = s2_sat_q;
        if (s1_valid_q) begin
            s2_sat_d = (sat_kind != SAT_NONE);
            unique case (sat_kind)
                SAT_HIGH: s2_data_d = SAT_HI[DATA_W-1:0];
                SAT_LOW:  s2_data_d = SAT_LO[DATA_W-1:0];
                default:  s2_data_d = shifted[DATA_W-1:0];
            endcase
        end
    end

    // ------------------------------------------------------- output buffer
    logic              fifo_empty;
    logic              fifo_full;
    logic [DATA_W-1:0] fifo_head;
    logic [LVL_W-1:0]  fifo_count;
    logic              drop;

    sync_fifo_fwft #(
        .WIDTH (DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_out_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (s2_valid_q),
        .push_data (s2_data_q),
        .pop       (data_out_ready),
        .head_data (fifo_head),
        .empty     (fifo_empty),
        .full      (fifo_full),
        .level     (fifo_count)
    );

    // A full FIFO still takes the new result if the head leaves this edge.
    assign drop = s2_valid_q && fifo_full && !data_out_ready;

    // --------------------------------------------------------------- overflow
    logic overflow_q, overflow_d;

    always_comb begin
        overflow_d = overflow_q;
        if ((s2_valid_q && s2_sat_q) || drop) begin
            overflow_d = 1'b1;
        end
    end

    // ------------------------------------------------------------- registers
    always_ff @(posedge clk) begin
        n_q     <= n_d;
        shift_q <= shift_d;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            acc_q      <= '0;
            cnt_q      <= '0;
            s1_valid_q <= 1'b0;
            s1_sum_q   <= '0;
            s2_valid_q <= 1'b0;
            s2_data_q  <= '0;
            s2_sat_q   <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            s1_valid_q <= s1_valid_d;
            s1_sum_q   <= s1_sum_d;
            s2_valid_q <= s2_valid_d;
            s2_data_q  <= s2_data_d;
            s2_sat_q   <= s2_sat_d;
            overflow_q <= overflow_d;
        end
    end

    // --------------------------------------------------------------- outputs
    assign data_out       = fifo_head;
    assign data_out_valid = !fifo_empty;
    assign fifo_level     = fifo_count;
    assign overflow       = overflow_q;

endmodule

// File: tb/tb_boxcar_decimator.sv
// -----------------------------------------------------------------------------
// tb_boxcar_decimator
//   Directed bench for boxcar_decimator with default parameters
//   (DATA_W=64, GUARD_W=16, FIFO_DEPTH=8). Inputs change and outputs are
//   observed 1 ns after each rising edge.
// -----------------------------------------------------------------------------
module tb_boxcar_decimator;

    localparam int DATA_W = 64;
    localparam int LVL_W  = 4;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              enable;
    logic [DATA_W-1:0] data_in;
    logic              data_in_valid;
    logic [15:0]       decim_factor;
    logic [5:0]        out_shift;
    logic [DATA_W-1:0] data_out;
    logic              data_out_valid;
    logic              data_out_ready;
    logic              overflow;
    logic [LVL_W-1:0]  fifo_level;

    int checks = 0;
    int fails  = 0;

    boxcar_decimator dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .enable         (enable),
        .data_in        (data_in),
        .data_in_valid  (data_in_valid),
        .decim_factor   (decim_factor),
        .out_shift      (out_shift),
        .data_out       (data_out),
        .data_out_valid (data_out_valid),
        .data_out_ready (data_out_ready),
        .overflow       (overflow),
        .fifo_level     (fifo_level)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Hold reset for one edge with the given configuration, then move the
    // configuration inputs to unrelated values that must have no effect.
    task automatic do_reset(input logic [15:0] n, input logic [5:0] sh);
        reset_n        = 1'b0;
        decim_factor   = n;
        out_shift      = sh;
        enable         = 1'b0;
        data_in_valid  = 1'b0;
        data_in        = '0;
        data_out_ready = 1'b0;
        tick();
        reset_n      = 1'b1;
        decim_factor = 16'd9;
        out_shift    = 6'd5;
    endtask

    task automatic send(input logic [63:0] v);
        enable        = 1'b1;
        data_in       = v;
        data_in_valid = 1'b1;
        tick();
        data_in_valid = 1'b0;
    endtask

    task automatic pop_one();
        data_out_ready = 1'b1;
        tick();
        data_out_ready = 1'b0;
    endtask

    initial begin
        // ---------------- basic decimation: N=4, shift=2
        do_reset(16'd4, 6'd2);
        check("rst_valid", 64'(data_out_valid), 64'd0);
        check("rst_data",  data_out,             64'd0);
        check("rst_level", 64'(fifo_level),     64'd0);
        check("rst_ovf",   64'(overflow),       64'd0);
        send(64'd1);
        send(64'd2);
        send(64'd3);
        send(64'd4);
        check("basic_lat0", 64'(data_out_valid), 64'd0);
        tick();
        check("basic_lat1", 64'(data_out_valid), 64'd0);
        tick();
        check("basic_valid", 64'(data_out_valid), 64'd1);
        check("basic_data",  data_out,            64'd2);
        check("basic_level", 64'(fifo_level),    64'd1);
        check("basic_ovf",   64'(overflow),      64'd0);
        pop_one();
        check("basic_drained", 64'(data_out_valid), 64'd0);

        // ---------------- N=0 behaves as N=1
        do_reset(16'd0, 6'd0);
        send(-64'sd5);
        send(64'd7);
        tick();
        tick();
        check("n0_level", 64'(fifo_level), 64'd2);
        check("n0_first", data_out,         -64'sd5);
        pop_one();
        check("n0_second", data_out,         64'd7);
        pop_one();
        check("n0_empty", 64'(data_out_valid), 64'd0);

        // ---------------- arithmetic shift of a negative sum: (-3 + -4) >>> 1
        do_reset(16'd2, 6'd1);
        send(-64'sd3);
        send(-64'sd4);
        tick();
        tick();
        check("neg_shift", data_out, -64'sd4);
        pop_one();

        // ---------------- saturation
        do_reset(16'd4, 6'd0);
        repeat (4) send(64'h7FFF_FFFF_FFFF_FFFF);
        tick();
        tick();
        check("sat_data", data_out,       64'h7FFF_FFFF_FFFF_FFFF);
        check("sat_ovf",  64'(overflow), 64'd1);
        pop_one();

        // ---------------- backpressure: 10 results into an 8-deep FIFO
        do_reset(16'd1, 6'd0);
        for (int i = 0; i < 10; i++) send(64'(i + 1));
        tick();
        tick();
        check("bp_level", 64'(fifo_level), 64'd8);
        check("bp_ovf",   64'(overflow),   64'd1);
        data_out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            check($sformatf("bp_valid%0d", i), 64'(data_out_valid), 64'd1);
            check($sformatf("bp_data%0d", i),  data_out,            64'(i + 1));
            tick();
        end
        data_out_ready = 1'b0;
        check("bp_empty", 64'(data_out_valid), 64'd0);

        // ---------------- push into a full FIFO with a simultaneous pop
        do_reset(16'd1, 6'd0);
        for (int i = 0; i < 8; i++) send(64'(i + 11));
        tick();
        tick();
        check("fp_full", 64'(fifo_level), 64'd8);
        send(64'd19);
        tick();
        data_out_ready = 1'b1;
        tick();
        data_out_ready = 1'b0;
        check("fp_level", 64'(fifo_level), 64'd8);
        check("fp_ovf",   64'(overflow),   64'd0);
        data_out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            check($sformatf("fp_data%0d", i), data_out, 64'(i + 12));
            tick();
        end
        data_out_ready = 1'b0;
        check("fp_empty", 64'(data_out_valid), 64'd0);

        // ---------------- gapping: enable low and data_in_valid gaps
        do_reset(16'd3, 6'd0);
        send(64'd10);
        send(64'd20);
        enable        = 1'b0;
        data_in       = 64'd1000;
        data_in_valid = 1'b1;
        repeat (5) tick();
        enable        = 1'b1;
        data_in_valid = 1'b0;
        repeat (2) tick();
        check("gap_idle", 64'(fifo_level), 64'd0);
        send(64'd30);
        tick();
        tick();
        check("gap_valid", 64'(data_out_valid), 64'd1);
        check("gap_data",  data_out,            64'd60);
        pop_one();

        // ---------------- reset mid-block with a buffered result
        do_reset(16'd4, 6'd0);
        send(64'd100);
        send(64'd200);
        send(64'd300);
        send(64'd400);
        send(64'd7);
        send(64'd8);
        check("mr_buffered", data_out, 64'd1000);
        do_reset(16'd2, 6'd0);
        check("mr_valid", 64'(data_out_valid), 64'd0);
        check("mr_data",  data_out,            64'd0);
        check("mr_level", 64'(fifo_level),    64'd0);
        send(64'd5);
        tick();
        tick();
        check("mr_partial", 64'(data_out_valid), 64'd0);
        send(64'd6);
        tick();
        tick();
        check("mr_out_valid", 64'(data_out_valid), 64'd1);
        check("mr_out_data",  data_out,            64'd11);

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
